lbph_seq_ctrl: RTL and testbench

LBPH_SEQ_CTRL -- requirements
Module: lbph_seq_ctrl

---
 rtl/lbph_pkg.sv | 10 +
 rtl/stage_watchdog.sv | 18 +
 rtl/lbph_seq_ctrl.sv | 87 ++++++++
 tb/tb_lbph_seq_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lbph_pkg.sv
// lbph_pkg: shared state encoding, sizing constants and address helper for the LBPH sequencer
package lbph_pkg;
  localparam int IMG_HIST_BYTES = 16384;
  localparam int MAX_TRAIN = 128;
  localparam int LABEL_W = 7;
  typedef enum logic [2:0] {IDLE, LBP_RUN, HCU_RUN, CMP_RUN, NEXT, FINISH} state_t;
  function automatic logic [20:0] hist_base(input logic [LABEL_W-1:0] idx);
    return 21'(idx) * 21'(IMG_HIST_BYTES);
  endfunction
endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: counts active stage cycles and flags the cycle in which the budget runs out
module stage_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/lbph_seq_ctrl.sv
// lbph_seq_ctrl: sequences LBP, histogram and compare stages over a training set or one probe image
module lbph_seq_ctrl
  import lbph_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [7:0]         num_train,
  output logic               lbp_start,
  input  logic               lbp_done,
  output logic               hcu_enable,
  output logic               hcu_mode,
  output logic [20:0]        hcu_base_addr,
  input  logic               hcu_done,
  output logic               cmp_start,
  input  logic               cmp_done,
  input  logic [LABEL_W-1:0] cmp_label,
  output logic [LABEL_W-1:0] img_idx,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] result_label,
  output logic               error
);
  state_t state, state_n;
  logic entry, expired, legal, stage_done, tmo, mode_q;
  logic [7:0] num_q;
  assign legal = mode || (num_train != 8'd0 && num_train <= 8'(MAX_TRAIN));
  assign stage_done = state == LBP_RUN ? lbp_done : state == HCU_RUN ? hcu_done : state == CMP_RUN && cmp_done;
  // a completion in the expiring cycle still counts as success
  assign tmo = expired && !stage_done;
  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(state_n != state),
    .en(state inside {LBP_RUN, HCU_RUN, CMP_RUN}),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      entry <= 1'b0;
    end else begin
      state <= state_n;
      entry <= state_n != state;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : legal ? LBP_RUN : FINISH;
      LBP_RUN: state_n = lbp_done ? HCU_RUN : tmo ? FINISH : LBP_RUN;
      HCU_RUN: state_n = hcu_done ? (mode_q ? CMP_RUN : NEXT) : tmo ? FINISH : HCU_RUN;
      CMP_RUN: state_n = cmp_done || tmo ? FINISH : CMP_RUN;
      NEXT:    state_n = {1'b0, img_idx} + 8'd1 < num_q ? LBP_RUN : FINISH;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    lbp_start = state == LBP_RUN && entry;
    cmp_start = state == CMP_RUN && entry;
    hcu_enable = state == HCU_RUN;
    busy = state != IDLE;
    done = state == FINISH;
    hcu_mode = mode_q;
    hcu_base_addr = mode_q ? 21'd0 : hist_base(img_idx);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= 1'b0;
      num_q <= 8'd0;
      img_idx <= '0;
      result_label <= '0;
      error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        num_q <= num_train;
        img_idx <= '0;
        error <= !legal;
      end
      if (tmo) error <= 1'b1;
      if (state == NEXT && state_n == LBP_RUN) img_idx <= img_idx + 1'b1;
      if (state == CMP_RUN && cmp_done) result_label <= cmp_label;
    end
endmodule

// File: tb/tb_lbph_seq_ctrl.sv
// tb_lbph_seq_ctrl: randomized stage responder plus run-level reference model for lbph_seq_ctrl
module tb_lbph_seq_ctrl;
  localparam int T = 20;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [7:0] num_train = 8'd0;
  logic lbp_start, lbp_done, hcu_enable, hcu_mode, hcu_done, cmp_start, cmp_done, busy, done, error;
  logic [20:0] hcu_base_addr;
  logic [6:0] cmp_label, img_idx, result_label;
  int checks = 0, failures = 0;
  int dl_g = 1, dh_g = 1, dc_g = 1;
  logic [6:0] lbl_g = 7'd0, last_label = 7'd0;
  bit stray = 1'b0, lf, hf, cf, hen_q = 1'b0;
  int lk = 0, hk = 0, ck = 0;
  int n_lbp = 0, n_cmp = 0, n_done = 0, n_hcu = 0, n_unstable = 0;
  logic [20:0] addr_log[4096];
  int len_log[4096];

  lbph_seq_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_train(num_train),
    .lbp_start(lbp_start), .lbp_done(lbp_done), .hcu_enable(hcu_enable), .hcu_mode(hcu_mode),
    .hcu_base_addr(hcu_base_addr), .hcu_done(hcu_done), .cmp_start(cmp_start), .cmp_done(cmp_done),
    .cmp_label(cmp_label), .img_idx(img_idx), .busy(busy), .done(done),
    .result_label(result_label), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // stage responders: each completion lands in stage cycle d, plus optional stray pulses
  always @(negedge clk) begin
    lk = lbp_start ? 1 : (lk != 0 ? lk + 1 : 0);
    lf = lk != 0 && lk == dl_g;
    if (lf) lk = 0;
    hk = hcu_enable ? hk + 1 : 0;
    hf = hcu_enable && hk == dh_g;
    ck = cmp_start ? 1 : (ck != 0 ? ck + 1 : 0);
    cf = ck != 0 && ck == dc_g;
    if (cf) ck = 0;
    lbp_done = lf | (stray && (hcu_enable || !busy) && $urandom_range(0, 7) == 0);
    hcu_done = hf | (stray && !busy && $urandom_range(0, 7) == 0);
    cmp_done = cf | (stray && (hcu_enable || !busy) && $urandom_range(0, 7) == 0);
    cmp_label = cf ? lbl_g : 7'($urandom);
  end

  always @(negedge clk) begin
    if (lbp_start) n_lbp++;
    if (cmp_start) n_cmp++;
    if (done) n_done++;
    if (hcu_enable && !hen_q) begin
      addr_log[n_hcu & 4095] = hcu_base_addr;
      len_log[n_hcu & 4095] = 1;
      n_hcu++;
    end else if (hcu_enable) begin
      len_log[(n_hcu - 1) & 4095]++;
      if (hcu_base_addr !== addr_log[(n_hcu - 1) & 4095]) n_unstable++;
    end
    hen_q = hcu_enable;
  end

  task automatic run(input bit m, input int n, input int dl, input int dh, input int dc, input int lbl, input bit restart);
    int s_lbp, s_cmp, s_done, s_hcu, s_uns, k, imgs;
    int e_lbp = 0, e_cmp = 0, e_hcu = 0, e_cyc = 0, e_idx = 0;
    bit e_err = 1'b0, legal;
    legal = m || (n >= 1 && n <= 128);
    if (!legal) begin
      e_err = 1'b1;
      e_cyc = 1;
    end else begin
      imgs = m ? 1 : n;
      for (int i = 0; i < imgs; i++) begin
        e_idx = i;
        e_lbp++;
        if (dl > T) begin e_cyc += T; e_err = 1'b1; break; end
        e_cyc += dl;
        e_hcu++;
        if (dh > T) begin e_cyc += T; e_err = 1'b1; break; end
        e_cyc += dh;
        if (m) begin
          e_cmp++;
          if (dc > T) begin e_cyc += T; e_err = 1'b1; end
          else begin e_cyc += dc; last_label = 7'(lbl); end
          break;
        end
        e_cyc += 1;
      end
      e_cyc += 1;
    end
    @(posedge clk);
    s_lbp = n_lbp; s_cmp = n_cmp; s_done = n_done; s_hcu = n_hcu; s_uns = n_unstable;
    @(negedge clk);
    dl_g = dl; dh_g = dh; dc_g = dc; lbl_g = 7'(lbl);
    mode = m; num_train = 8'(n); start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (restart && k == 3 && !done) begin
        start = 1'b1;
        mode = ~m;
        num_train = 8'($urandom);
      end
    end while (!done && k < 20000);
    check("done_seen", done, 1);
    check("run_cycles", k, e_cyc);
    check("error", error, e_err);
    check("result_label", result_label, last_label);
    check("img_idx", img_idx, e_idx);
    check("hcu_mode", hcu_mode, m);
    check("hcu_en_at_done", hcu_enable, 0);
    @(negedge clk);
    check("busy_after", busy, 0);
    check("done_width", done, 0);
    repeat (3) @(negedge clk);
    check("label_hold", result_label, last_label);
    @(posedge clk);
    check("lbp_starts", n_lbp - s_lbp, e_lbp);
    check("cmp_starts", n_cmp - s_cmp, e_cmp);
    check("done_count", n_done - s_done, 1);
    check("hcu_runs", n_hcu - s_hcu, e_hcu);
    check("addr_stable", n_unstable - s_uns, 0);
    for (int j = 0; j < e_hcu && j < n_hcu - s_hcu; j++) begin
      check("hcu_addr", addr_log[(s_hcu + j) & 4095], m ? 0 : j * 16384);
      check("hcu_len", len_log[(s_hcu + j) & 4095], dh > T ? T : dh);
    end
  endtask

  initial begin
    int k, n, sel;
    repeat (3) @(negedge clk);
    check("rst_outputs", {lbp_start, hcu_enable, hcu_mode, hcu_base_addr, cmp_start, img_idx, busy, done, result_label, error}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_rst", busy, 0);
    run(0, 3, 10, 10, 10, 0, 0);
    run(1, 5, 7, 9, 4, 42, 0);
    check("pred_label_42", result_label, 42);
    run(0, 1, 10, 1000, 10, 0, 0);
    run(0, 0, 5, 5, 5, 0, 0);
    run(0, 200, 5, 5, 5, 0, 0);
    run(1, 0, 3, 3, 3, 17, 0);
    run(0, 4, 5, 6, 1, 0, 1);
    run(0, 128, 3, 3, 1, 0, 0);
    check("addr_128_last", addr_log[(n_hcu - 1) & 4095], 2080768);
    run(0, 2, T, T, 1, 0, 0);
    run(1, 1, T + 10, 5, 5, 9, 0);
    run(1, 1, 5, 5, T + 5, 9, 0);
    run(1, 1, 5, 5, T, 99, 0);
    @(negedge clk);
    mode = 1'b0; num_train = 8'd3; dl_g = 10; dh_g = 10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!hcu_enable && k < 100) begin @(negedge clk); k++; end
    check("reach_hcu", hcu_enable, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", {lbp_start, hcu_enable, hcu_mode, hcu_base_addr, cmp_start, img_idx, busy, done, result_label, error}, 0);
    @(negedge clk);
    rst = 1'b0;
    last_label = 7'd0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run(0, 3, 10, 10, 10, 0, 0);
    stray = 1'b1;
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 9);
      n = sel == 0 ? 0 : sel == 1 ? $urandom_range(129, 255) : $urandom_range(1, 6);
      run(1'($urandom_range(0, 1)), n, $urandom_range(1, 24), $urandom_range(1, 24),
          $urandom_range(1, 24), $urandom_range(0, 127), $urandom_range(0, 3) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
